// File: rtl/jedro_1_pkg.sv
// rtl/jedro_1_pkg.sv - shared types and constants for the jedro_1 register file sequencer
package jedro_1_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 5;

   // Index of the hard-wired zero register
   localparam int REG_ZERO = 0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD1  = 3'd1,
      RD2  = 3'd2,
      WAIT = 3'd3,
      RESP = 3'd4
   } rf_state_e;

endpackage

// File: rtl/jedro_1_regfile_ctrl.sv
// rtl/jedro_1_regfile_ctrl.sv - serialises rs1/rs2 reads and writeback writes onto one regfile port
module jedro_1_regfile_ctrl
   import jedro_1_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  rd_valid_i,
   output logic                  rd_ready_o,
   input  logic [ADDR_WIDTH-1:0] rd_rs1_i,
   input  logic [ADDR_WIDTH-1:0] rd_rs2_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rs1_data_o,
   output logic [DATA_WIDTH-1:0] rsp_rs2_data_o,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic [ADDR_WIDTH-1:0] rf_addr_o,
   output logic [DATA_WIDTH-1:0] rf_data_o,
   output logic                  rf_we_o,
   input  logic [DATA_WIDTH-1:0] rf_data_i
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

   rf_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] rs1_q, rs2_q;
   logic [DATA_WIDTH-1:0] rs1_data_q;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_rs1_q, rsp_rs2_q;

   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_rs1_data_o = rsp_rs1_q;
   assign rsp_rs2_data_o = rsp_rs2_q;

   // Handshakes are gated by rstn_i so nothing is accepted while reset is held
   always_comb begin
      state_d    = state_q;
      rd_ready_o = rstn_i && (state_q == IDLE) && !wr_valid_i;
      wr_ready_o = rstn_i && ((state_q == IDLE) || (state_q == RESP));
      rf_we_o    = 1'b0;
      rf_addr_o  = '0;
      rf_data_o  = '0;
      if (wr_valid_i && wr_ready_o) begin
         rf_we_o   = 1'b1;
         rf_addr_o = wr_addr_i;
         rf_data_o = wr_data_i;
      end
      case (state_q)
         IDLE: if (rd_valid_i && rd_ready_o) state_d = RD1;
         RD1: begin
            rf_addr_o = rs1_q;
            state_d   = RD2;
         end
         RD2: begin
            rf_addr_o = rs2_q;
            state_d   = WAIT;
         end
         WAIT: begin
            rf_addr_o = rs2_q;
            state_d   = RESP;
         end
         RESP: if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rs1_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rs1_q   <= '0;
         rsp_rs2_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (rd_valid_i && rd_ready_o) begin
               rs1_q <= rd_rs1_i;
               rs2_q <= rd_rs2_i;
            end
            RD2: rs1_data_q <= (rs1_q == ZERO_IDX) ? '0 : rf_data_i;
            WAIT: begin
               rsp_rs1_q   <= rs1_data_q;
               rsp_rs2_q   <= (rs2_q == ZERO_IDX) ? '0 : rf_data_i;
               rsp_valid_q <= 1'b1;
            end
            RESP: if (rsp_ready_i) rsp_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jedro_1_regfile_ctrl.sv
// tb/tb_jedro_1_regfile_ctrl.sv - directed self-checking bench for jedro_1_regfile_ctrl
module tb_jedro_1_regfile_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic          rd_valid_i, rd_ready_o;
   logic [AW-1:0] rd_rs1_i, rd_rs2_i;
   logic          rsp_valid_o, rsp_ready_i;
   logic [DW-1:0] rsp_rs1_data_o, rsp_rs2_data_o;
   logic          wr_valid_i, wr_ready_o;
   logic [AW-1:0] wr_addr_i;
   logic [DW-1:0] wr_data_i;
   logic [AW-1:0] rf_addr_o;
   logic [DW-1:0] rf_data_o;
   logic          rf_we_o;
   logic [DW-1:0] rf_data_i;

   always #5 clk_i = ~clk_i;

   jedro_1_regfile_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o),
      .rd_rs1_i(rd_rs1_i), .rd_rs2_i(rd_rs2_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rs1_data_o(rsp_rs1_data_o), .rsp_rs2_data_o(rsp_rs2_data_o),
      .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o), .rf_we_o(rf_we_o),
      .rf_data_i(rf_data_i)
   );

   // Register file model: one-cycle read latency, writes to x0 dropped, x0 holds garbage
   logic [DW-1:0] mem [0:31];
   initial begin
      mem[0] = 32'hFFFF_FFFF;
      for (int i = 1; i < 32; i++) mem[i] = 32'h1000_0000 + i;
      rf_data_i = '0;
   end
   always @(posedge clk_i) begin
      if (rf_we_o && rf_addr_o != 0) mem[rf_addr_o] <= rf_data_o;
      rf_data_i <= mem[rf_addr_o];
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // All tasks start and end just after a falling edge
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_valid_i = 1'b1; wr_addr_i = a; wr_data_i = d;
      #1;
      chk("wr_ready", wr_ready_o, 1'b1);
      chk("wr_we", rf_we_o, 1'b1);
      chk("wr_addr", rf_addr_o, a);
      chk("wr_data", rf_data_o, d);
      @(posedge clk_i); @(negedge clk_i);
      wr_valid_i = 1'b0;
      #1;
   endtask

   task automatic rd_issue(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [DW-1:0] e1, input logic [DW-1:0] e2);
      int n, lat;
      rd_valid_i = 1'b1; rd_rs1_i = a; rd_rs2_i = b;
      #1;
      n = 0;
      while (!rd_ready_o && n < 20) begin @(negedge clk_i); #1; n++; end
      chk("rd_accept", n < 20, 1'b1);
      @(posedge clk_i); @(negedge clk_i);
      rd_valid_i = 1'b0;
      #1;
      lat = 1;
      while (!rsp_valid_o && lat < 20) begin @(negedge clk_i); #1; lat++; end
      chk("rd_latency", lat, 4);
      chk("rsp_rs1", rsp_rs1_data_o, e1);
      chk("rsp_rs2", rsp_rs2_data_o, e2);
   endtask

   task automatic rsp_take();
      rsp_ready_i = 1'b1;
      @(posedge clk_i); @(negedge clk_i);
      rsp_ready_i = 1'b0;
      #1;
      chk("rsp_cleared", rsp_valid_o, 1'b0);
      chk("back_idle", rd_ready_o, 1'b1);
   endtask

   logic [AW-1:0] p1 [3];
   logic [AW-1:0] p2 [3];
   initial begin
      logic seen;
      int t_prev;
      p1[0] = 5'd1; p2[0] = 5'd2;
      p1[1] = 5'd3; p2[1] = 5'd4;
      p1[2] = 5'd2; p2[2] = 5'd1;

      rstn_i = 1'b0; rsp_ready_i = 1'b0;
      wr_valid_i = 1'b1; wr_addr_i = 5'd9; wr_data_i = 32'hA5A5_A5A5;
      rd_valid_i = 1'b1; rd_rs1_i = 5'd3; rd_rs2_i = 5'd4;
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_rd_ready", rd_ready_o, 1'b0);
      chk("rst_wr_ready", wr_ready_o, 1'b0);
      chk("rst_rsp_valid", rsp_valid_o, 1'b0);
      chk("rst_rsp_rs1", rsp_rs1_data_o, 32'h0);
      chk("rst_rsp_rs2", rsp_rs2_data_o, 32'h0);
      chk("rst_rf_we", rf_we_o, 1'b0);
      chk("rst_rf_addr", rf_addr_o, 32'h0);
      chk("rst_rf_data", rf_data_o, 32'h0);
      wr_valid_i = 1'b0; rd_valid_i = 1'b0;
      rstn_i = 1'b1;
      #1;
      chk("post_rst_rd_ready", rd_ready_o, 1'b1);

      // write then read with rs2 = x0
      @(negedge clk_i); #1;
      do_write(5'd5, 32'hDEAD_BEEF);
      rd_issue(5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0);
      rsp_take();

      // write and read requested in the same cycle
      wr_valid_i = 1'b1; wr_addr_i = 5'd7; wr_data_i = 32'h1234_5678;
      rd_valid_i = 1'b1; rd_rs1_i = 5'd7; rd_rs2_i = 5'd7;
      #1;
      chk("conflict_rd_ready", rd_ready_o, 1'b0);
      chk("conflict_we", rf_we_o, 1'b1);
      @(posedge clk_i); @(negedge clk_i);
      wr_valid_i = 1'b0;
      #1;
      chk("conflict_rd_next", rd_ready_o, 1'b1);
      rd_issue(5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678);

      // backpressure with a write landing during RESP
      do_write(5'd7, 32'h0);
      repeat (9) @(negedge clk_i);
      #1;
      chk("bp_valid", rsp_valid_o, 1'b1);
      chk("bp_rs1", rsp_rs1_data_o, 32'h1234_5678);
      chk("bp_rs2", rsp_rs2_data_o, 32'h1234_5678);
      rsp_take();
      rd_issue(5'd7, 5'd7, 32'h0, 32'h0);
      rsp_take();

      // write to x0 is issued, rs1 = x0 reads as zero
      do_write(5'd0, 32'h0000_0055);
      rd_issue(5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF);
      rsp_take();

      // reset while in RD2
      rd_valid_i = 1'b1; rd_rs1_i = 5'd5; rd_rs2_i = 5'd7;
      @(posedge clk_i); @(negedge clk_i);
      rd_valid_i = 1'b0;
      #1;
      chk("rd1_addr", rf_addr_o, 5'd5);
      @(posedge clk_i); @(negedge clk_i); #1;
      chk("rd2_addr", rf_addr_o, 5'd7);
      rstn_i = 1'b0;
      #1;
      chk("midrst_valid", rsp_valid_o, 1'b0);
      chk("midrst_addr", rf_addr_o, 5'd0);
      chk("midrst_rd_ready", rd_ready_o, 1'b0);
      @(posedge clk_i); @(negedge clk_i);
      rstn_i = 1'b1;
      #1;
      chk("midrst_idle", rd_ready_o, 1'b1);
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk_i); @(negedge clk_i); #1;
         if (rsp_valid_o) seen = 1'b1;
      end
      chk("midrst_no_rsp", seen, 1'b0);
      rd_issue(5'd5, 5'd7, 32'hDEAD_BEEF, 32'h0);
      rsp_take();

      // back-to-back reads with rsp_ready held high
      rsp_ready_i = 1'b1;
      rd_valid_i = 1'b1; rd_rs1_i = p1[0]; rd_rs2_i = p2[0];
      #1;
      t_prev = cyc;
      for (int k = 0; k < 3; k++) begin
         chk("b2b_accept", rd_ready_o, 1'b1);
         if (k > 0) chk("b2b_period", cyc - t_prev, 5);
         t_prev = cyc;
         @(posedge clk_i); @(negedge clk_i); #1;
         chk("b2b_addr_rs1", rf_addr_o, p1[k]);
         @(posedge clk_i); @(negedge clk_i); #1;
         chk("b2b_addr_rs2a", rf_addr_o, p2[k]);
         @(posedge clk_i); @(negedge clk_i); #1;
         chk("b2b_addr_rs2b", rf_addr_o, p2[k]);
         @(posedge clk_i); @(negedge clk_i); #1;
         chk("b2b_valid", rsp_valid_o, 1'b1);
         chk("b2b_rs1", rsp_rs1_data_o, 32'h1000_0000 + p1[k]);
         chk("b2b_rs2", rsp_rs2_data_o, 32'h1000_0000 + p2[k]);
         if (k < 2) begin
            rd_rs1_i = p1[k+1]; rd_rs2_i = p2[k+1];
         end else begin
            rd_valid_i = 1'b0;
         end
         @(posedge clk_i); @(negedge clk_i); #1;
      end
      chk("b2b_end_valid", rsp_valid_o, 1'b0);
      rsp_ready_i = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
